// File: rtl/alu_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_8bit
//  Purpose  : 8-bit registered ALU with 16 operations selected by a 4-bit
//             opcode. The result of the selected operation and a zero flag
//             are registered on the rising edge of clk (latency 1, one
//             operation per cycle).
//  Ports    : clk        - system clock, rising-edge active
//             rst        - asynchronous active-high reset
//             a, b       - 8-bit unsigned operands
//             opcode     - 4-bit operation select
//             resultado  - registered 8-bit result
//             zero       - registered flag, 1 when resultado is 8'h00
//  Revision : 1.0  initial release
// ============================================================================
module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] opcode,
  output logic [7:0] resultado,
  output logic       zero
);

  localparam logic [3:0] c_OP_ADD  = 4'h0;
  localparam logic [3:0] c_OP_SUB  = 4'h1;
  localparam logic [3:0] c_OP_MUL  = 4'h2;
  localparam logic [3:0] c_OP_DIV  = 4'h3;
  localparam logic [3:0] c_OP_SHL  = 4'h4;
  localparam logic [3:0] c_OP_SHR  = 4'h5;
  localparam logic [3:0] c_OP_ROL  = 4'h6;
  localparam logic [3:0] c_OP_ROR  = 4'h7;
  localparam logic [3:0] c_OP_AND  = 4'h8;
  localparam logic [3:0] c_OP_OR   = 4'h9;
  localparam logic [3:0] c_OP_XOR  = 4'hA;
  localparam logic [3:0] c_OP_NOR  = 4'hB;
  localparam logic [3:0] c_OP_NAND = 4'hC;
  localparam logic [3:0] c_OP_XNOR = 4'hD;
  localparam logic [3:0] c_OP_GT   = 4'hE;
  localparam logic [3:0] c_OP_EQ   = 4'hF;

  logic [7:0] result_d;
  logic       zero_d;
  logic [7:0] result_q;
  logic       zero_q;

  // Next-result selection; carries and high product bits fall off because
  // every arithmetic expression is evaluated in an 8-bit context.
  always_comb begin
    result_d = 8'h00;
    unique case (opcode)
      c_OP_ADD:  result_d = a + b;
      c_OP_SUB:  result_d = a - b;
      c_OP_MUL:  result_d = a * b;
      // Division by zero saturates to all-ones instead of being undefined.
      c_OP_DIV:  result_d = (b == 8'h00) ? 8'hFF : (a / b);
      c_OP_SHL:  result_d = {a[6:0], 1'b0};
      c_OP_SHR:  result_d = {1'b0, a[7:1]};
      c_OP_ROL:  result_d = {a[6:0], a[7]};
      c_OP_ROR:  result_d = {a[0], a[7:1]};
      c_OP_AND:  result_d = a & b;
      c_OP_OR:   result_d = a | b;
      c_OP_XOR:  result_d = a ^ b;
      c_OP_NOR:  result_d = ~(a | b);
      c_OP_NAND: result_d = ~(a & b);
      c_OP_XNOR: result_d = ~(a ^ b);
      c_OP_GT:   result_d = {7'b0, (a > b)};
      c_OP_EQ:   result_d = {7'b0, (a == b)};
      default:   result_d = 8'h00;
    endcase
  end

  // Flag is taken from the value about to be registered so that both
  // outputs always describe the same operation.
  assign zero_d = (result_d == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 8'h00;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign resultado = result_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_8bit
//  Purpose  : Self-checking bench for alu_8bit: directed corner cases plus
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic [7:0] resultado;
  logic       zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .resultado (resultado),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reference model computed with plain integer arithmetic.
  function automatic logic [7:0] ref_op(input int op, input int x, input int y);
    int r;
    case (op)
      0:  r = (x + y) % 256;
      1:  r = (x - y + 256) % 256;
      2:  r = (x * y) % 256;
      3:  r = (y == 0) ? 255 : x / y;
      4:  r = (x * 2) % 256;
      5:  r = x / 2;
      6:  r = (x * 2) % 256 + x / 128;
      7:  r = (x % 2) * 128 + x / 2;
      8:  r = x & y;
      9:  r = x | y;
      10: r = x ^ y;
      11: r = 255 - (x | y);
      12: r = 255 - (x & y);
      13: r = 255 - (x ^ y);
      14: r = (x > y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  // Apply one operation, clock it, and check both outputs just after the edge.
  task automatic step(input string tag, input int op, input int x, input int y);
    logic [7:0] exp;
    opcode = op[3:0];
    a      = x[7:0];
    b      = y[7:0];
    exp    = ref_op(op, x, y);
    @(posedge clk);
    #1;
    check_eq({tag, ".res"}, resultado, exp);
    check_eq({tag, ".zero"}, {7'b0, zero}, {7'b0, exp == 8'h00});
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1; a = 8'h0A; b = 8'h02; opcode = 4'h0;
    #1;
    check_eq("reset.res", resultado, 8'h00);
    check_eq("reset.zero", {7'b0, zero}, 8'h01);
    @(posedge clk); #1;
    rst = 1'b0;

    // Opcode sweep; expected values written out from the data sheet table.
    begin
      logic [7:0] sweep [16] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                 8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
      for (int i = 0; i < 16; i++) begin
        opcode = i[3:0]; a = 8'h0A; b = 8'h02;
        @(posedge clk); #1;
        check_eq($sformatf("sweep%0d.res", i), resultado, sweep[i]);
        check_eq($sformatf("sweep%0d.zero", i), {7'b0, zero}, (i == 15) ? 8'h01 : 8'h00);
      end
    end

    step("add_wrap", 0, 8'hFF, 8'h01);
    step("sub_wrap", 1, 8'h00, 8'h01);
    step("mul_wrap", 2, 8'h10, 8'h10);
    step("div0",     3, 8'h37, 8'h00);
    step("div_lt",   3, 8'h01, 8'h02);
    step("rol81",    6, 8'h81, 8'h00);
    step("ror81",    7, 8'h81, 8'h00);
    step("shl81",    4, 8'h81, 8'hFF);
    step("shr81",    5, 8'h81, 8'hFF);
    step("gt_uns",  14, 8'h80, 8'h7F);
    step("eq5a",    15, 8'h5A, 8'h5A);
    check_eq("eq5a.lit", resultado, 8'h01);

    // Outputs must hold between edges when inputs move.
    step("hold", 0, 8'h21, 8'h12);
    held = resultado;
    opcode = 4'h2; a = 8'h77; b = 8'h33;
    #3;
    check_eq("hold.after_change", resultado, 8'h33);

    // Mid-stream asynchronous reset: takes effect without an edge and
    // discards the operation that was set up.
    rst = 1'b1;
    #0.5;
    check_eq("async_rst.res", resultado, 8'h00);
    check_eq("async_rst.zero", {7'b0, zero}, 8'h01);
    @(posedge clk); #1;
    check_eq("rst_held.res", resultado, 8'h00);
    rst = 1'b0;
    step("post_rst", 0, 8'h0A, 8'h02);
    check_eq("post_rst.lit", resultado, 8'h0C);

    // Randomized back-to-back operations, opcode changing every cycle.
    for (int i = 0; i < 300; i++) begin
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           (i % 8 == 0) ? 0 : int'($urandom_range(0, 255)));
    end

    if (held !== 8'h33) begin
      n_checks++;
      n_errors++;
      $display("FAIL hold.capture: got %02h expected 33", held);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_8bit.md
# alu_8bit

8-bit registered arithmetic/logic unit with 16 operations selected by a 4-bit opcode. Both operands and the opcode are sampled on every rising clock edge. The selected result and a zero flag appear on registered outputs one cycle later. The block is the datapath execution unit of the processor project and feeds the register file write-back and the branch/compare logic.

## Interface
- No parameters; data width is fixed at 8 bits and opcode width at 4 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  8  operand A, unsigned.
- b  input  8  operand B, unsigned.
- opcode  input  4  operation select.
- resultado  output  8  registered result of the selected operation.
- zero  output  1  registered flag; 1 when the resultado value registered in the same edge is 8'h00.

## Operation
- Opcode map:
  - 0 ADD: a+b mod 256.
  - 1 SUB: a−b mod 256.
  - 2 MUL: low 8 bits of a*b.
  - 3 DIV: floor(a/b); b=0 gives 8'hFF.
  - 4 SHL: a<<1, with 0 shifted in.
  - 5 SHR: a>>1 logical, with 0 shifted in.
  - 6 ROL: {a[6:0],a[7]}.
  - 7 ROR: {a[0],a[7:1]}.
  - 8 AND: a&b.
  - 9 OR: a|b.
  - A XOR: a^b.
  - B NOR: ~(a|b).
  - C NAND: ~(a&b).
  - D XNOR: ~(a^b).
  - E GT: 8'h01 if a>b unsigned, else 8'h00.
  - F EQ: 8'h01 if a==b, else 8'h00.
- Shifts and rotates use operand A only; b is ignored.
- No carry, overflow or remainder outputs. Carries and high product bits are discarded.
- zero is derived from the next result value, not from the previously registered one, so it always matches the resultado value registered on the same edge.
- All 16 opcode values are defined; there is no illegal opcode.

## Timing
- Result computation is combinational; resultado and zero are registered at the rising edge of clk.
- Latency: exactly 1 cycle. Inputs stable before edge N produce outputs valid after edge N.
- Throughput: one operation per cycle. Operands and opcode may change every cycle; no handshake and no valid signal.
- Reset: while rst=1, resultado=8'h00 and zero=1. Reset takes effect immediately, independent of clk.
- On reset deassertion, the first update happens at the next rising edge.
- Reset asserted mid-stream discards the operation in flight.
- Outputs hold their value between edges even if inputs change.

## Test plan
- Reset: assert rst with a=8'h0A, b=8'h02 -> resultado=8'h00 and zero=1 immediately, without a clock edge. Release rst -> first computed result appears after the next edge.
- Opcode sweep with a=8'h0A, b=8'h02, opcode 0..F on successive cycles -> results one cycle later:
  - 0C, 08, 14, 05 (ADD, SUB, MUL, DIV)
  - 14, 05, 14, 05 (SHL, SHR, ROL, ROR)
  - 02, 0A, 08, F5 (AND, OR, XOR, NOR)
  - FD, F7, 01, 00 (NAND, XNOR, GT, EQ)
  - zero=1 only for EQ.
- Wrap and zero flag:
  - ADD a=8'hFF, b=8'h01 -> 8'h00, zero=1.
  - SUB a=8'h00, b=8'h01 -> 8'hFF, zero=0.
  - MUL a=8'h10, b=8'h10 -> 8'h00, zero=1.
- Divide by zero: DIV a=8'h37, b=8'h00 -> 8'hFF, zero=0. DIV a=8'h01, b=8'h02 -> 8'h00, zero=1.
- Rotate/shift edges with a=8'h81:
  - ROL -> 8'h03; ROR -> 8'hC0.
  - SHL -> 8'h02; SHR -> 8'h40.
- Back-to-back and compare:
  - Change opcode every cycle and check each output lags its inputs by exactly one edge.
  - GT a=8'h80, b=8'h7F -> 8'h01 (unsigned compare).
  - EQ a=b=8'h5A -> 8'h01.
